// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto one memory port, one outstanding transaction.
// Define COTM32_MEM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_valid,
  input  logic [ADDR_W-1:0]        if_req_addr,
  output logic                     if_req_ready,
  output logic                     if_rsp_valid,
  output logic [DATA_W-1:0]        if_rsp_rdata,
  input  logic                     ls_req_valid,
  input  logic [ADDR_W-1:0]        ls_req_addr,
  input  logic                     ls_req_we,
  input  logic [DATA_W/8-1:0]      ls_req_be,
  input  logic [DATA_W-1:0]        ls_req_wdata,
  output logic                     ls_req_ready,
  output logic                     ls_rsp_valid,
  output logic [DATA_W-1:0]        ls_rsp_rdata,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W/8-1:0]      mem_be,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy
);

  localparam int BYTE_WIDTH = 8;
  localparam int BE_W       = DATA_W / BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                gnt_ls_q, gnt_ls_d;
  logic                pick_ls;
  logic                any_req;

`ifdef COTM32_MEM_ARB_RR_EN
  logic                last_ls_q, last_ls_d;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    pick_ls = ls_req_valid && !(if_req_valid && last_ls_q);
  end
`else
  always_comb begin
    pick_ls = ls_req_valid;
  end
`endif

  assign any_req = if_req_valid | ls_req_valid;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    gnt_ls_d = gnt_ls_q;
`ifdef COTM32_MEM_ARB_RR_EN
    last_ls_d = last_ls_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ISSUE;
          gnt_ls_d = pick_ls;
`ifdef COTM32_MEM_ARB_RR_EN
          last_ls_d = pick_ls;
`endif
          if (pick_ls) begin
            addr_d  = ls_req_addr;
            we_d    = ls_req_we;
            be_d    = ls_req_be;
            wdata_d = ls_req_wdata;
          end else begin
            addr_d  = if_req_addr;
            we_d    = 1'b0;
            be_d    = '1;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        // Stores complete with zero data so the LSU sees a clean write acknowledge.
        if (mem_rsp_valid) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_ls_q <= 1'b0;
`ifdef COTM32_MEM_ARB_RR_EN
      last_ls_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_ls_q <= gnt_ls_d;
`ifdef COTM32_MEM_ARB_RR_EN
      last_ls_q <= last_ls_d;
`endif
    end
  end

  // Ready is combinational from the grant decision, and forced low while reset is held.
  assign if_req_ready  = !rst && (state_q == IDLE) && if_req_valid && !pick_ls;
  assign ls_req_ready  = !rst && (state_q == IDLE) && pick_ls;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;

  assign if_rsp_valid  = (state_q == RESP) && !gnt_ls_q;
  assign ls_rsp_valid  = (state_q == RESP) && gnt_ls_q;
  assign if_rsp_rdata  = rdata_q;
  assign ls_rsp_rdata  = rdata_q;

  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// Define COTM32_MEM_ARB_RR_EN to match a round-robin build of the DUT.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        ls_req_valid;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [3:0]  ls_req_be;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_we(ls_req_we),
    .ls_req_be(ls_req_be), .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: intended memory contents and who won the last grant.
  logic [31:0] ref_mem [16];
  // Memory device contents, written only through what the DUT presents.
  logic [31:0] dev_mem [16];
  bit          ref_last_ls;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic bit ref_grant(input bit iv, input bit lv);
    bit g;
`ifdef COTM32_MEM_ARB_RR_EN
    g = (iv && lv) ? !ref_last_ls : lv;
`else
    g = lv;
`endif
    ref_last_ls = g;
    return g;
  endfunction

  task automatic scramble_reqs();
    if_req_valid = 1'($urandom);
    if_req_addr  = $urandom;
    ls_req_valid = 1'($urandom);
    ls_req_addr  = $urandom;
    ls_req_we    = 1'($urandom);
    ls_req_be    = 4'($urandom);
    ls_req_wdata = $urandom;
  endtask

  task automatic idle_reqs();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
  endtask

  task automatic quiet_checks(input string tag);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_ifrdy"}, if_req_ready, 1'b0);
    chk({tag, "_lsrdy"}, ls_req_ready, 1'b0);
    chk({tag, "_ifrsp"}, if_rsp_valid, 1'b0);
    chk({tag, "_lsrsp"}, ls_rsp_valid, 1'b0);
  endtask

  // One full transaction; entered just after a rising edge with the DUT idle.
  task automatic txn(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                     input bit lwe, input logic [3:0] lbe, input logic [31:0] lwd,
                     input int rdly, input int sdly, output bit won_ls);
    bit          w;
    logic [31:0] e_addr, e_wd, e_rd;
    bit          e_we;
    logic [3:0]  e_be;
    int          idx;
    w = ref_grant(iv, lv);
    won_ls = w;
    if (w) begin
      e_addr = la; e_we = lwe; e_be = lbe; e_wd = lwd;
    end else begin
      e_addr = ia; e_we = 1'b0; e_be = 4'hF; e_wd = '0;
    end
    idx = int'(e_addr[5:2]);
    if (e_we) begin
      ref_mem[idx] = merge(ref_mem[idx], e_wd, e_be);
      e_rd = '0;
    end else begin
      e_rd = ref_mem[idx];
    end

    if_req_valid = iv; if_req_addr = ia;
    ls_req_valid = lv; ls_req_addr = la; ls_req_we = lwe; ls_req_be = lbe; ls_req_wdata = lwd;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_mreqv", mem_req_valid, 1'b0);
    chk("grant_ifrdy", if_req_ready, !w);
    chk("grant_lsrdy", ls_req_ready, w);
    @(posedge clk); #1;

    for (int c = 0; c <= rdly; c++) begin
      scramble_reqs();
      mem_req_ready = (c == rdly);
      mem_rsp_valid = 1'($urandom);
      @(negedge clk);
      chk("iss_mreqv", mem_req_valid, 1'b1);
      chk("iss_addr", mem_addr, e_addr);
      chk("iss_we", mem_we, e_we);
      chk("iss_be", mem_be, e_be);
      if (e_we) chk("iss_wdata", mem_wdata, e_wd);
      quiet_checks("iss");
      if (c == rdly && mem_req_valid && mem_we)
        dev_mem[mem_addr[5:2]] = merge(dev_mem[mem_addr[5:2]], mem_wdata, mem_be);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;

    for (int c = 0; c <= sdly; c++) begin
      scramble_reqs();
      mem_rsp_valid = (c == sdly);
      mem_rdata = (c == sdly && !e_we) ? dev_mem[mem_addr[5:2]] : $urandom;
      @(negedge clk);
      chk("wait_mreqv", mem_req_valid, 1'b0);
      quiet_checks("wait");
      @(posedge clk); #1;
    end

    scramble_reqs();
    mem_rsp_valid = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    chk("resp_ifv", if_rsp_valid, !w);
    chk("resp_lsv", ls_rsp_valid, w);
    chk("resp_rdata", w ? ls_rsp_rdata : if_rsp_rdata, e_rd);
    chk("resp_busy", busy, 1'b1);
    chk("resp_ifrdy", if_req_ready, 1'b0);
    chk("resp_lsrdy", ls_req_ready, 1'b0);
    @(posedge clk); #1;
    idle_reqs();
    mem_rsp_valid = 1'($urandom);
    @(negedge clk);
    chk("post_ifv", if_rsp_valid, 1'b0);
    chk("post_lsv", ls_rsp_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
  endtask

  bit won;
  bit exp_seq [4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    ref_last_ls = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    if_req_addr = 32'h40; ls_req_addr = 32'h80; ls_req_we = 1'b0;
    ls_req_be = 4'hF; ls_req_wdata = '0;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    rst = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mreqv", mem_req_valid, 1'b0);
    chk("rst_ifrdy", if_req_ready, 1'b0);
    chk("rst_lsrdy", ls_req_ready, 1'b0);
    chk("rst_ifv", if_rsp_valid, 1'b0);
    chk("rst_lsv", ls_rsp_valid, 1'b0);
    chk("rst_ifdata", if_rsp_rdata, 32'h0);
    chk("rst_lsdata", ls_rsp_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", mem_be, 4'h0);
    @(posedge clk); #1;
    chk("rst_hold_busy", busy, 1'b0);
    chk("rst_hold_ifrdy", if_req_ready, 1'b0);
    idle_reqs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention right after reset: last grant starts as fetch.
`ifdef COTM32_MEM_ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 32'h200 + 32'(i*4), 1'b1, 32'h300 + 32'(i*4), 1'b0, 4'hF, 32'h0, 0, 0, won);
      chk("contend_winner", won, exp_seq[i]);
    end

    // Single fetch with an immediate memory.
    ref_mem[0] = 32'h00000013; dev_mem[0] = 32'h00000013;
    txn(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, won);
    chk("fetch_winner", won, 1'b0);

    // Store with write-acknowledge, then read the word back.
    txn(1'b0, 32'h0, 1'b1, 32'h804, 1'b1, 4'b0011, 32'hDEADBEEF, 0, 0, won);
    chk("store_winner", won, 1'b1);
    txn(1'b0, 32'h0, 1'b1, 32'h804, 1'b0, 4'hF, 32'h0, 0, 1, won);

    // Back-pressure for three cycles.
    txn(1'b1, 32'h10C, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 3, 2, won);

    // Reset while waiting on memory: the transaction and a late response are dropped.
    if_req_valid = 1'b1; if_req_addr = 32'h110;
    @(posedge clk); #1;
    idle_reqs();
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rstw_inwait_busy", busy, 1'b1);
    chk("rstw_inwait_mreqv", mem_req_valid, 1'b0);
    #1;
    rst = 1'b1;
    if_req_valid = 1'b1;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_ifrdy", if_req_ready, 1'b0);
    ref_last_ls = 1'b0;
    @(posedge clk); #1;
    idle_reqs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBADBAD00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw_ifv", if_rsp_valid, 1'b0);
      chk("rstw_lsv", ls_rsp_valid, 1'b0);
      chk("rstw_idle", busy, 1'b0);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
    end
    txn(1'b1, 32'h114, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1, 0, won);
    chk("rstw_next_winner", won, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int sel;
      int gap;
      sel = int'($urandom_range(1, 3));
      txn(sel[0], $urandom, sel[1], $urandom, 1'($urandom), 4'($urandom), $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), won);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        mem_rsp_valid = 1'($urandom);
        @(negedge clk);
        chk("gap_busy", busy, 1'b0);
        chk("gap_ifv", if_rsp_valid, 1'b0);
        chk("gap_lsv", ls_rsp_valid, 1'b0);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
